uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver.
- Supports configurable data width, optional parity and 1 or 2 stop bits.
- Samples each bit at mid-bit from an oversample tick and reports parity, framing and overrun errors.
- Presents received bytes through a one-entry valid/ready holding register.
- Sits between the shared baud/oversample tick generator and the consumer (FIFO or bus bridge).

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked, legal 1 or 2
OVERSAMPLE, 16, os_tick pulses per bit period, even, legal 8..32

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (rst==0 resets on next clk edge)
os_tick  in  1  one-cycle enable, OVERSAMPLE pulses per bit
rx  in  1  asynchronous serial line, idle high
rx_data  out  DATA_BITS  received word, stable while rx_valid=1
rx_valid  out  1  holding register full
rx_ready  in  1  consumer accepts word when rx_valid & rx_ready
parity_err  out  1  parity mismatch for word in holding register, qualified by rx_valid
frame_err  out  1  stop bit sampled 0 for word in holding register, qualified by rx_valid
overrun  out  1  one-cycle pulse, a completed frame was dropped
busy  out  1  high whenever state != IDLE

Behaviour:
Reset:
- State goes to IDLE; sample and bit counters are 0.
- rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, rx_data=0.
- The synchroniser flops load 1.
- Reset mid-frame abandons the frame; no output is produced.

Synchroniser and counters:
- rx passes through 2 flops to give rx_s; rx-to-rx_s latency is 2 clk.
- All sampling uses rx_s. Counters advance only on os_tick.
- The sample counter is log2(OVERSAMPLE) bits wide and wraps at OVERSAMPLE-1.

States:
- IDLE: on rx_s==0, go to START and clear the sample counter.
- START: at tick count OVERSAMPLE/2-1, sample rx_s.
  - If 1 (glitch), go to IDLE with no output.
  - If 0, clear the counter and go to DATA. The counter is now aligned to mid-bit.
- DATA: every OVERSAMPLE ticks, sample rx_s into shift register bit [bit_idx], LSB first.
  - After DATA_BITS samples, go to PAR if PARITY!=0, else go to STOP.
- PAR: after OVERSAMPLE ticks, sample the parity bit.
  - Computed error = XOR(data, sampled bit) != (PARITY==1 ? 1 : 0).
- STOP: every OVERSAMPLE ticks, sample one stop bit, STOP_BITS times.
  - Any stop sample of 0 sets the frame error.
  - After the last stop sample, commit the frame.
  - Go to IDLE if the last sample was 1, else go to BRK_WAIT.
- BRK_WAIT: wait until rx_s==1, then go to IDLE. A held-low break produces exactly one frame_err word.

Commit (clk after the last stop-sample tick):
- If rx_valid==0 or rx_ready==1 in that cycle, load rx_data, parity_err and frame_err, and set rx_valid=1.
- Otherwise keep the old word and pulse overrun for 1 clk; the new frame is discarded.

Handshake:
- rx_valid clears on the cycle after rx_valid & rx_ready unless a commit happens in the same cycle.
- Simultaneous accept and commit: the new word replaces the old one, rx_valid stays 1, no overrun.
- rx_valid never drops without an accept.

Timing and widths:
- os_tick in every state other than the ones above has no effect.
- An os_tick during reset is ignored.
- The bit counter is log2(DATA_BITS+1) bits wide. No arithmetic overflow exists beyond the counter wraps defined above.

Decomposition:
- Package uart_pkg holds:
  - the state encoding localparams (IDLE, START, DATA, PAR, STOP, BRK_WAIT);
  - parity mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - clog2-based width helpers, shared with the transmitter.
- One sub-module, uart_sync2: 2-flop synchroniser with reset value parameter (1 here), reusable by other async inputs.
- FSM, counters, shift register and holding register stay in uart_rx_param.

Test Plan:
1. Default 8N1, OVERSAMPLE=16, send 0xA5 at exact bit timing -> rx_valid=1 with rx_data=0xA5, parity_err=0, frame_err=0. With rx_ready=1, rx_valid drops after 1 clk.
2. Line low for 4 os_ticks then high -> START aborts, state back to IDLE, no rx_valid, busy pulses then 0.
3. PARITY=2, DATA_BITS=7: send 0x35 with correct even parity bit 0 -> parity_err=0. Resend with parity bit 1 -> rx_data=0x35, parity_err=1.
4. STOP_BITS=2, send 0x3C with second stop bit 0 -> frame_err=1, rx_data=0x3C. Hold line low 40 bit times -> no further words, then recovery on the next valid frame 0x81.
5. rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once at the second commit. Raise rx_ready -> 0x11 accepted, rx_valid=0.
6. Assert rst=0 for 1 clk during DATA bit 4 of 0xF0 -> all outputs at reset values, no word committed. Next frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes and width helpers
// used by both the receiver and the transmitter.
package uart_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] PAR      = 3'd3;
  localparam logic [2:0] STOP     = 3'd4;
  localparam logic [2:0] BRK_WAIT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = IDLE,
    S_START    = START,
    S_DATA     = DATA,
    S_PAR      = PAR,
    S_STOP     = STOP,
    S_BRK_WAIT = BRK_WAIT
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input, with a
// configurable reset value.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, optional parity,
// 1-2 stop bits and a one-entry valid/ready holding register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SW = cnt_w(OVERSAMPLE);
  localparam int BW = cnt_w(DATA_BITS + 1);
  localparam logic [SW-1:0] CNT_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] CNT_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] CNT_ONE  = SW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STP_LAST = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic PAR_EXP = (PARITY == PAR_ODD);

  logic rx_s;

  rx_state_e            state_q, state_d;
  logic [SW-1:0]        cnt_q, cnt_d, cnt_nx;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 fperr_q, fperr_d;
  logic                 fferr_q, fferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 tick_end;
  logic                 commit;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fperr_d  = fperr_q;
    fferr_d  = fferr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    ovr_d    = 1'b0;
    commit   = 1'b0;
    cnt_nx   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
    tick_end = os_tick && (cnt_q == CNT_LAST);

    if (valid_q && rx_ready) valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (os_tick) begin
          if (cnt_q == CNT_MID) begin
            cnt_d   = '0;
            bit_d   = '0;
            fperr_d = 1'b0;
            fferr_d = 1'b0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_nx;
          end
        end
      end
      S_DATA: begin
        if (os_tick) cnt_d = cnt_nx;
        if (tick_end) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_ONE;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
          end
        end
      end
      S_PAR: begin
        if (os_tick) cnt_d = cnt_nx;
        if (tick_end) begin
          fperr_d = ((^shift_q) ^ rx_s) != PAR_EXP;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (os_tick) cnt_d = cnt_nx;
        if (tick_end) begin
          if (!rx_s) fferr_d = 1'b1;
          bit_d = bit_q + BIT_ONE;
          if (bit_q == STP_LAST) begin
            commit  = 1'b1;
            bit_d   = '0;
            state_d = rx_s ? S_IDLE : S_BRK_WAIT;
          end
        end
      end
      S_BRK_WAIT: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An accept in the same cycle frees the slot for the new word.
    if (commit) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        perr_d  = fperr_d;
        ferr_d  = fferr_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      fperr_q <= 1'b0;
      fferr_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      fperr_q <= fperr_d;
      fferr_q <= fferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 7E1, 8N2/OS8)
// driven from a shared tick, with vector table, corner cases and random frames.
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic os_tick = 1'b0;
  logic [2:0] rx = 3'b111;
  logic [2:0] rdy = 3'b000;

  logic [2:0] vld, perr, ferr, ovr, bsy;
  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;
  logic [2:0][8:0] dat;

  assign dat[0] = {1'b0, d0};
  assign dat[1] = {2'b00, d1};
  assign dat[2] = {1'b0, d2};

  always #5 clk = ~clk;
  always @(negedge clk) os_tick <= ~os_tick;

  uart_rx_param u0 (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rx(rx[0]),
    .rx_data(d0), .rx_valid(vld[0]), .rx_ready(rdy[0]),
    .parity_err(perr[0]), .frame_err(ferr[0]),
    .overrun(ovr[0]), .busy(bsy[0])
  );

  uart_rx_param #(
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)
  ) u1 (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rx(rx[1]),
    .rx_data(d1), .rx_valid(vld[1]), .rx_ready(rdy[1]),
    .parity_err(perr[1]), .frame_err(ferr[1]),
    .overrun(ovr[1]), .busy(bsy[1])
  );

  uart_rx_param #(
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(8)
  ) u2 (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rx(rx[2]),
    .rx_data(d2), .rx_valid(vld[2]), .rx_ready(rdy[2]),
    .parity_err(perr[2]), .frame_err(ferr[2]),
    .overrun(ovr[2]), .busy(bsy[2])
  );

  typedef struct {
    int         inst;
    logic [8:0] d;
    bit         pe;
    bit         fe;
  } exp_t;

  typedef struct {
    int         inst;
    logic [8:0] d;
    bit         pbad;
    bit         stop0;
    logic [8:0] xd;
    bit         xpe;
    bit         xfe;
  } vec_t;

  exp_t expq[$];
  int total = 0;
  int bad = 0;
  int acc_cnt [3] = '{0, 0, 0};
  int ovr_cnt [3] = '{0, 0, 0};
  bit [2:0] mon_en = 3'b000;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ovr[i]) ovr_cnt[i]++;
      if (vld[i] && rdy[i]) begin
        acc_cnt[i]++;
        if (mon_en[i]) begin
          if (expq.size() == 0) begin
            chk("mon_unexpected_word", 32'(i), 32'hFF);
          end else begin
            exp_t e;
            e = expq.pop_front();
            chk("mon_inst", 32'(i), 32'(e.inst));
            chk("mon_data", 32'(dat[i]), 32'(e.d));
            chk("mon_perr", 32'(perr[i]), 32'(e.pe));
            chk("mon_ferr", 32'(ferr[i]), 32'(e.fe));
          end
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!os_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic bit_out(input int inst, input logic v, input int os);
    rx[inst] = v;
    wait_ticks(os);
  endtask

  // Frame layout follows each instance's configuration; the expected
  // word is derived from the bits actually put on the line.
  task automatic send(input int inst, input logic [8:0] d, input bit pbad,
                      input bit stop0, input int hold, input bit push);
    int nb, pm, ns, os, ones;
    logic pb;
    exp_t e;
    nb = (inst == 1) ? 7 : 8;
    pm = (inst == 1) ? 2 : 0;
    ns = (inst == 2) ? 2 : 1;
    os = (inst == 2) ? 8 : 16;
    ones = 0;
    pb = 1'b0;
    bit_out(inst, 1'b0, os);
    for (int k = 0; k < nb; k++) begin
      bit_out(inst, d[k], os);
      ones += int'(d[k]);
    end
    if (pm != 0) begin
      pb = (pm == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
      pb = pb ^ pbad;
    end
    if (push) begin
      e.inst = inst;
      e.d = (nb == 7) ? (d & 9'h07F) : (d & 9'h0FF);
      e.pe = (pm == 0) ? 1'b0 :
             (((ones + int'(pb)) % 2) != ((pm == 1) ? 1 : 0));
      e.fe = stop0;
      expq.push_back(e);
    end
    if (pm != 0) bit_out(inst, pb, os);
    for (int s = 0; s < ns; s++)
      bit_out(inst, !(stop0 && s == ns - 1), os);
    if (stop0) wait_ticks(hold * os);
    rx[inst] = 1'b1;
    wait_ticks(2 * os);
  endtask

  task automatic pulse_ready(input int inst);
    @(posedge clk); #1;
    rdy[inst] = 1'b1;
    @(posedge clk); #1;
    rdy[inst] = 1'b0;
  endtask

  vec_t tbl [7];

  initial begin
    int a0, o0;
    bit saw_busy;

    tbl[0] = '{0, 9'h0A5, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0};
    tbl[1] = '{1, 9'h035, 1'b0, 1'b0, 9'h035, 1'b0, 1'b0};
    tbl[2] = '{1, 9'h035, 1'b1, 1'b0, 9'h035, 1'b1, 1'b0};
    tbl[3] = '{2, 9'h03C, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b1};
    tbl[4] = '{0, 9'h000, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
    tbl[5] = '{0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b1};
    tbl[6] = '{2, 9'h081, 1'b0, 1'b0, 9'h081, 1'b0, 1'b0};

    repeat (4) @(posedge clk);
    #1;
    chk("rst_valid", 32'(vld), 32'h0);
    chk("rst_busy", 32'(bsy), 32'h0);
    chk("rst_data", 32'(d0), 32'h0);
    chk("rst_perr_ferr", 32'({perr, ferr}), 32'h0);
    chk("rst_ovr", 32'(ovr), 32'h0);
    rst = 1'b1;
    wait_ticks(8);

    for (int v = 0; v < 7; v++) begin
      send(tbl[v].inst, tbl[v].d, tbl[v].pbad, tbl[v].stop0, 0, 1'b0);
      chk($sformatf("vec%0d_valid", v), 32'(vld[tbl[v].inst]), 32'h1);
      chk($sformatf("vec%0d_data", v), 32'(dat[tbl[v].inst]), 32'(tbl[v].xd));
      chk($sformatf("vec%0d_perr", v), 32'(perr[tbl[v].inst]), 32'(tbl[v].xpe));
      chk($sformatf("vec%0d_ferr", v), 32'(ferr[tbl[v].inst]), 32'(tbl[v].xfe));
      pulse_ready(tbl[v].inst);
      chk($sformatf("vec%0d_drop", v), 32'(vld[tbl[v].inst]), 32'h0);
    end

    a0 = acc_cnt[0];
    rx[0] = 1'b0;
    wait_ticks(4);
    saw_busy = bsy[0];
    rx[0] = 1'b1;
    wait_ticks(24);
    chk("glitch_busy_seen", 32'(saw_busy), 32'h1);
    chk("glitch_busy_end", 32'(bsy[0]), 32'h0);
    chk("glitch_no_valid", 32'(vld[0]), 32'h0);

    mon_en[2] = 1'b1;
    rdy[2] = 1'b1;
    a0 = acc_cnt[2];
    send(2, 9'h03C, 1'b0, 1'b1, 40, 1'b1);
    chk("break_one_word", 32'(acc_cnt[2] - a0), 32'h1);
    send(2, 9'h081, 1'b0, 1'b0, 0, 1'b1);
    chk("break_recover", 32'(acc_cnt[2] - a0), 32'h2);
    mon_en[2] = 1'b0;
    rdy[2] = 1'b0;

    o0 = ovr_cnt[0];
    send(0, 9'h011, 1'b0, 1'b0, 0, 1'b0);
    send(0, 9'h022, 1'b0, 1'b0, 0, 1'b0);
    chk("ovr_valid", 32'(vld[0]), 32'h1);
    chk("ovr_keep_old", 32'(d0), 32'h11);
    chk("ovr_pulse_once", 32'(ovr_cnt[0] - o0), 32'h1);
    pulse_ready(0);
    chk("ovr_accept", 32'(vld[0]), 32'h0);

    fork
      send(0, 9'h0F0, 1'b0, 1'b0, 0, 1'b0);
    join_none
    wait_ticks(88);
    chk("mid_busy_before_rst", 32'(bsy[0]), 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(vld[0]), 32'h0);
    chk("mid_rst_busy", 32'(bsy[0]), 32'h0);
    chk("mid_rst_data", 32'(d0), 32'h0);
    rst = 1'b1;
    wait fork;
    chk("mid_no_word", 32'(vld[0]), 32'h0);
    mon_en[0] = 1'b1;
    rdy[0] = 1'b1;
    a0 = acc_cnt[0];
    send(0, 9'h05A, 1'b0, 1'b0, 0, 1'b1);
    chk("mid_next_word", 32'(acc_cnt[0] - a0), 32'h1);

    for (int n = 0; n < 30; n++) begin
      send(0, 9'($urandom_range(0, 255)), 1'b0,
           ($urandom_range(0, 9) == 0), $urandom_range(0, 3), 1'b1);
      wait_ticks($urandom_range(0, 5));
    end
    mon_en[0] = 1'b0;
    rdy[0] = 1'b0;

    mon_en[1] = 1'b1;
    rdy[1] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      send(1, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
           1'b0, 0, 1'b1);
      wait_ticks($urandom_range(0, 5));
    end
    wait_ticks(40);
    chk("queue_drained", 32'(expq.size()), 32'h0);
    chk("no_stray_overrun", 32'(ovr_cnt[1] + ovr_cnt[2]), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
